// File: rtl/agc_pkg.sv
// -----------------------------------------------------------------------------
// agc_pkg
// Shared definitions for the AGC control sequencer:
//   - instruction opcodes (mem_data[14:12])
//   - ALU command codes
//   - datapath mux select encodings
//   - sequencer state enum and the packed control word
//   - small helpers describing instruction length
// Optional feature macro: AGC_INDEX_EN (INDEX instruction support; when
// undefined, opcode 2 is a one-state NOOP).
// -----------------------------------------------------------------------------
package agc_pkg;

    // Opcodes
    localparam logic [2:0] OP_TC    = 3'd0;
    localparam logic [2:0] OP_CCS   = 3'd1;
    localparam logic [2:0] OP_INDEX = 3'd2;
    localparam logic [2:0] OP_XCH   = 3'd3;
    localparam logic [2:0] OP_CS    = 3'd4;
    localparam logic [2:0] OP_TS    = 3'd5;
    localparam logic [2:0] OP_AD    = 3'd6;
    localparam logic [2:0] OP_MASK  = 3'd7;

    // ALU commands
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd4;

    // Memory address mux
    localparam logic [1:0] MADDR_PC = 2'd0;
    localparam logic [1:0] MADDR_S  = 2'd1;
    localparam logic [1:0] MADDR_A  = 2'd2;

    // A register source mux
    localparam logic [1:0] AMUX_MEM  = 2'd0;
    localparam logic [1:0] AMUX_U    = 2'd1;
    localparam logic [1:0] AMUX_NOTA = 2'd2;
    localparam logic [1:0] AMUX_G    = 2'd3;

    // X register source mux
    localparam logic [1:0] XMUX_MEM = 2'd0;
    localparam logic [1:0] XMUX_Z   = 2'd1;
    localparam logic [1:0] XMUX_S   = 2'd2;
    localparam logic [1:0] XMUX_A   = 2'd3;

    // Y register source mux
    localparam logic [1:0] YMUX_MEM = 2'd0;
    localparam logic [1:0] YMUX_A   = 2'd1;
    localparam logic [1:0] YMUX_ONE = 2'd2;
    localparam logic [1:0] YMUX_IMM = 2'd3;

    // B register source mux
    localparam logic BMUX_MEM = 1'b0;

    // Sequencer states: two fetch states then up to four execute states
    typedef enum logic [2:0] {
        ST_F0 = 3'd0,
        ST_F1 = 3'd1,
        ST_E0 = 3'd2,
        ST_E1 = 3'd3,
        ST_E2 = 3'd4,
        ST_E3 = 3'd5
    } state_e;

    // Every datapath control driven by the sequencer
    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] maddr_mux;
        logic [1:0] q_mux;
        logic [1:0] a_mux;
        logic [1:0] x_mux;
        logic [1:0] z_mux;
        logic [1:0] y_mux;
        logic       lp_mux;
        logic       b_mux;
        logic       lp_we;
        logic       g_we;
        logic       q_we;
        logic       b_we;
        logic       a_we;
        logic       y_we;
        logic       x_we;
        logic       z_we;
        logic       mem_we;
        logic       instr_done;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '0;

    // True for the execute states
    function automatic logic is_exec(input state_e st);
        logic r;
        case (st)
            ST_E0, ST_E1, ST_E2, ST_E3: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

    // Final execute state of each instruction
    function automatic state_e last_exec(input logic [2:0] op);
        state_e r;
        case (op)
            OP_TC, OP_TS:                 r = ST_E0;
            OP_CCS:                       r = ST_E3;
            OP_XCH, OP_CS, OP_AD, OP_MASK: r = ST_E2;
`ifdef AGC_INDEX_EN
            OP_INDEX:                     r = ST_E1;
`else
            OP_INDEX:                     r = ST_E0;
`endif
            default:                      r = ST_E0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/agc_ctl_decode.sv
// -----------------------------------------------------------------------------
// agc_ctl_decode
// Purely combinational decode of {state, opcode} into the datapath control
// word. F0 decodes to all-zero; F1 loads B from memory; execute states follow
// the per-opcode micro-sequences.
// Optional feature macro: AGC_INDEX_EN (INDEX reads its operand in E0).
// Ports:
//   state   in   sequencer state
//   opcode  in   3-bit instruction opcode
//   ctl     out  control word (see agc_pkg::ctl_t)
// -----------------------------------------------------------------------------
module agc_ctl_decode
    import agc_pkg::*;
(
    input  state_e     state,
    input  logic [2:0] opcode,
    output ctl_t       ctl
);

    // Control word for the given state/opcode pair
    always_comb begin
        ctl = CTL_IDLE;
        case (state)
            ST_F0: begin
                ctl = CTL_IDLE;
            end
            ST_F1: begin
                ctl.b_we  = 1'b1;
                ctl.b_mux = BMUX_MEM;
            end
            ST_E0, ST_E1, ST_E2, ST_E3: begin
                case (opcode)
                    OP_CCS: begin
                        case (state)
                            ST_E0: ctl.maddr_mux = MADDR_S;
                            ST_E1: begin
                                ctl.a_we  = 1'b1;
                                ctl.a_mux = AMUX_MEM;
                            end
                            ST_E2: begin
                                // X <= A, Y <= 1 so E3 computes A - 1 (diminished abs)
                                ctl.x_we  = 1'b1;
                                ctl.x_mux = XMUX_A;
                                ctl.y_we  = 1'b1;
                                ctl.y_mux = YMUX_ONE;
                            end
                            ST_E3: begin
                                ctl.alu_op = ALU_SUB;
                                ctl.a_we   = 1'b1;
                                ctl.a_mux  = AMUX_U;
                            end
                            default: ctl = CTL_IDLE;
                        endcase
                    end
                    OP_INDEX: begin
`ifdef AGC_INDEX_EN
                        if (state == ST_E0) begin
                            ctl.maddr_mux = MADDR_S;
                        end else begin
                            ctl.maddr_mux = MADDR_PC;
                        end
`else
                        ctl = CTL_IDLE;
`endif
                    end
                    OP_XCH: begin
                        case (state)
                            ST_E0: ctl.maddr_mux = MADDR_S;
                            ST_E1: begin
                                ctl.maddr_mux = MADDR_S;
                                ctl.g_we      = 1'b1;
                                ctl.mem_we    = 1'b1;
                            end
                            ST_E2: begin
                                ctl.a_we  = 1'b1;
                                ctl.a_mux = AMUX_G;
                            end
                            default: ctl = CTL_IDLE;
                        endcase
                    end
                    OP_CS: begin
                        case (state)
                            ST_E0: ctl.maddr_mux = MADDR_S;
                            ST_E1: begin
                                ctl.a_we  = 1'b1;
                                ctl.a_mux = AMUX_MEM;
                            end
                            ST_E2: begin
                                ctl.a_we  = 1'b1;
                                ctl.a_mux = AMUX_NOTA;
                            end
                            default: ctl = CTL_IDLE;
                        endcase
                    end
                    OP_TS: begin
                        if (state == ST_E0) begin
                            ctl.maddr_mux = MADDR_S;
                            ctl.mem_we    = 1'b1;
                        end else begin
                            ctl = CTL_IDLE;
                        end
                    end
                    OP_AD, OP_MASK: begin
                        case (state)
                            ST_E0: ctl.maddr_mux = MADDR_S;
                            ST_E1: begin
                                ctl.y_we  = 1'b1;
                                ctl.y_mux = YMUX_MEM;
                                ctl.x_we  = 1'b1;
                                ctl.x_mux = XMUX_A;
                            end
                            ST_E2: begin
                                ctl.alu_op = (opcode == OP_MASK) ? ALU_AND : ALU_ADD;
                                ctl.a_we   = 1'b1;
                                ctl.a_mux  = AMUX_U;
                            end
                            default: ctl = CTL_IDLE;
                        endcase
                    end
                    default: ctl = CTL_IDLE;   // TC only changes pc
                endcase
            end
            default: ctl = CTL_IDLE;
        endcase

        if (is_exec(state) && (state == last_exec(opcode))) begin
            ctl.instr_done = 1'b1;
        end else begin
            ctl.instr_done = 1'b0;
        end
    end

endmodule

// File: rtl/agc_sequencer.sv
// -----------------------------------------------------------------------------
// agc_sequencer
// Control sequencer for the AGC datapath. Fetches an instruction (F0/F1),
// then walks the opcode's execute states, one state per clock, driving every
// datapath enable, mux select and alu_op. Owns the program counter.
// Optional feature macro: AGC_INDEX_EN (INDEX instruction and idx register;
// without it opcode 2 is a NOOP).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   halt                  stall in F0 while high
//   mem_data[15:0]        memory read data ([14:12] opcode, [11:0] address)
//   acc_sign, acc_zero    accumulator sign / zero-magnitude flags for CCS
//   pc_addr               fetch address
//   alu_op, *_MUX, *_WE   datapath controls (registered)
//   instr_done            one-cycle pulse in the last execute state
// -----------------------------------------------------------------------------
module agc_sequencer
    import agc_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(12'h000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic [15:0]       mem_data,
    input  logic              acc_sign,
    input  logic              acc_zero,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [2:0]        alu_op,
    output logic [1:0]        MAddr_MUX,
    output logic [1:0]        Q_MUX,
    output logic [1:0]        A_MUX,
    output logic [1:0]        X_MUX,
    output logic [1:0]        Z_MUX,
    output logic [1:0]        Y_MUX,
    output logic              LP_MUX,
    output logic              B_MUX,
    output logic              LP_WE,
    output logic              G_WE,
    output logic              Q_WE,
    output logic              B_WE,
    output logic              A_WE,
    output logic              Y_WE,
    output logic              X_WE,
    output logic              Z_WE,
    output logic              mem_WE,
    output logic              instr_done
);

    state_e            state_r;
    state_e            state_nx_s;
    logic [ADDR_W-1:0] pc_r;
    logic [2:0]        ir_op_r;
    logic [ADDR_W-1:0] ir_k_r;
    logic [2:0]        op_nx_s;
    logic [ADDR_W-1:0] k_load_s;
    logic [ADDR_W-1:0] skip_s;
    ctl_t              ctl_r;
    ctl_t              ctl_nx_s;
    logic              unused_s;
`ifdef AGC_INDEX_EN
    logic [ADDR_W-1:0] idx_r;
`endif

    // Bit 15 of the instruction word carries no meaning for the sequencer
    assign unused_s = mem_data[15];

    // Next state: halt is only honoured in F0, instructions always complete
    always_comb begin
        state_nx_s = ST_F0;
        case (state_r)
            ST_F0: begin
                if (halt) begin
                    state_nx_s = ST_F0;
                end else begin
                    state_nx_s = ST_F1;
                end
            end
            ST_F1: state_nx_s = ST_E0;
            ST_E0: begin
                if (last_exec(ir_op_r) == ST_E0) begin
                    state_nx_s = ST_F0;
                end else begin
                    state_nx_s = ST_E1;
                end
            end
            ST_E1: begin
                if (last_exec(ir_op_r) == ST_E1) begin
                    state_nx_s = ST_F0;
                end else begin
                    state_nx_s = ST_E2;
                end
            end
            ST_E2: begin
                if (last_exec(ir_op_r) == ST_E2) begin
                    state_nx_s = ST_F0;
                end else begin
                    state_nx_s = ST_E3;
                end
            end
            ST_E3:   state_nx_s = ST_F0;
            default: state_nx_s = ST_F0;
        endcase
    end

    // Opcode that will be in force next cycle (the new one is on mem_data during F1)
    always_comb begin
        if (state_r == ST_F1) begin
            op_nx_s = mem_data[14:12];
        end else begin
            op_nx_s = ir_op_r;
        end
    end

    // Effective address captured at F1; a pending index offset is folded in here
    always_comb begin
`ifdef AGC_INDEX_EN
        k_load_s = ADDR_W'(mem_data[11:0]) + idx_r;
`else
        k_load_s = ADDR_W'(mem_data[11:0]);
`endif
    end

    // CCS skip distance: >+0 -> 0, +0 -> 1, <-0 -> 2, -0 -> 3
    always_comb begin
        case ({acc_sign, acc_zero})
            2'b00:   skip_s = ADDR_W'(2'd0);
            2'b01:   skip_s = ADDR_W'(2'd1);
            2'b10:   skip_s = ADDR_W'(2'd2);
            2'b11:   skip_s = ADDR_W'(2'd3);
            default: skip_s = ADDR_W'(2'd0);
        endcase
    end

    // Decode the control word of the upcoming state so the outputs come from a register
    agc_ctl_decode u_decode (
        .state  (state_nx_s),
        .opcode (op_nx_s),
        .ctl    (ctl_nx_s)
    );

    // Sequencer state, program counter, instruction register and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_F0;
            pc_r    <= RESET_PC;
            ir_op_r <= 3'd0;
            ir_k_r  <= '0;
            ctl_r   <= CTL_IDLE;
`ifdef AGC_INDEX_EN
            idx_r   <= '0;
`endif
        end else begin
            state_r <= state_nx_s;
            ctl_r   <= ctl_nx_s;
            case (state_r)
                ST_F1: begin
                    pc_r    <= pc_r + ADDR_W'(1'b1);
                    ir_op_r <= mem_data[14:12];
                    ir_k_r  <= k_load_s;
`ifdef AGC_INDEX_EN
                    idx_r   <= '0;
`endif
                end
                ST_E0: begin
                    if (ir_op_r == OP_TC) begin
                        pc_r <= ir_k_r;
                    end
                end
`ifdef AGC_INDEX_EN
                ST_E1: begin
                    // Operand read in E0 is valid now
                    if (ir_op_r == OP_INDEX) begin
                        idx_r <= ADDR_W'(mem_data[11:0]);
                    end
                end
`endif
                ST_E2: begin
                    // A was loaded in E1, so the flags describe the operand
                    if (ir_op_r == OP_CCS) begin
                        pc_r <= pc_r + skip_s;
                    end
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    assign pc_addr    = pc_r;
    assign alu_op     = ctl_r.alu_op;
    assign MAddr_MUX  = ctl_r.maddr_mux;
    assign Q_MUX      = ctl_r.q_mux;
    assign A_MUX      = ctl_r.a_mux;
    assign X_MUX      = ctl_r.x_mux;
    assign Z_MUX      = ctl_r.z_mux;
    assign Y_MUX      = ctl_r.y_mux;
    assign LP_MUX     = ctl_r.lp_mux;
    assign B_MUX      = ctl_r.b_mux;
    assign LP_WE      = ctl_r.lp_we;
    assign G_WE       = ctl_r.g_we;
    assign Q_WE       = ctl_r.q_we;
    assign B_WE       = ctl_r.b_we;
    assign A_WE       = ctl_r.a_we;
    assign Y_WE       = ctl_r.y_we;
    assign X_WE       = ctl_r.x_we;
    assign Z_WE       = ctl_r.z_we;
    assign mem_WE     = ctl_r.mem_we;
    assign instr_done = ctl_r.instr_done;

endmodule

// File: tb/tb_agc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_agc_sequencer
// Runs a small program through agc_sequencer with a synchronous-read memory.
// A cycle model built from the instruction step tables predicts pc_addr and
// the whole control word each cycle; directed checks pin specific scenarios.
// Optional feature macro: AGC_INDEX_EN.
// -----------------------------------------------------------------------------
module tb_agc_sequencer;

    localparam int PH_F0 = -2;
    localparam int PH_F1 = -1;
`ifdef AGC_INDEX_EN
    localparam bit INDEX_EN = 1'b1;
`else
    localparam bit INDEX_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        halt;
    logic [15:0] mem_data;
    logic        acc_sign;
    logic        acc_zero;
    logic [11:0] pc_addr;
    logic [2:0]  alu_op;
    logic [1:0]  MAddr_MUX, Q_MUX, A_MUX, X_MUX, Z_MUX, Y_MUX;
    logic        LP_MUX, B_MUX;
    logic        LP_WE, G_WE, Q_WE, B_WE, A_WE, Y_WE, X_WE, Z_WE, mem_WE;
    logic        instr_done;

    agc_sequencer #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clk(clk), .reset(reset), .halt(halt), .mem_data(mem_data),
        .acc_sign(acc_sign), .acc_zero(acc_zero), .pc_addr(pc_addr),
        .alu_op(alu_op), .MAddr_MUX(MAddr_MUX), .Q_MUX(Q_MUX), .A_MUX(A_MUX),
        .X_MUX(X_MUX), .Z_MUX(Z_MUX), .Y_MUX(Y_MUX), .LP_MUX(LP_MUX),
        .B_MUX(B_MUX), .LP_WE(LP_WE), .G_WE(G_WE), .Q_WE(Q_WE), .B_WE(B_WE),
        .A_WE(A_WE), .Y_WE(Y_WE), .X_WE(X_WE), .Z_WE(Z_WE), .mem_WE(mem_WE),
        .instr_done(instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    logic [15:0] mem [0:4095];
    logic [26:0] act;

    // model state
    int          m_phase;
    logic [2:0]  m_op;
    logic [11:0] m_pc;
    logic [11:0] m_k;
    logic [11:0] m_idx;

    assign act = {alu_op, MAddr_MUX, Q_MUX, A_MUX, X_MUX, Z_MUX, Y_MUX, LP_MUX, B_MUX,
                  LP_WE, G_WE, Q_WE, B_WE, A_WE, Y_WE, X_WE, Z_WE, mem_WE, instr_done};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // number of execute steps for an opcode
    function automatic int steps(input logic [2:0] op);
        case (op)
            3'd0, 3'd5: return 1;
            3'd1:       return 4;
            3'd2:       return INDEX_EN ? 2 : 1;
            default:    return 3;
        endcase
    endfunction

    // control word required in a given step of an instruction
    function automatic logic [26:0] exp_ctl(input int phase, input logic [2:0] op);
        logic [2:0] alu;
        logic [1:0] ma, am, xm, ym;
        logic bwe, gwe, awe, ywe, xwe, mwe, dn;
        alu = 3'd0; ma = 2'd0; am = 2'd0; xm = 2'd0; ym = 2'd0;
        bwe = 1'b0; gwe = 1'b0; awe = 1'b0; ywe = 1'b0; xwe = 1'b0; mwe = 1'b0; dn = 1'b0;
        if (phase == PH_F1) begin
            bwe = 1'b1;
        end else if (phase >= 0) begin
            dn = (phase == steps(op) - 1);
            case (op)
                3'd1: begin
                    if (phase == 0) ma = 2'd1;
                    if (phase == 1) begin awe = 1'b1; am = 2'd0; end
                    if (phase == 2) begin xwe = 1'b1; xm = 2'd3; ywe = 1'b1; ym = 2'd2; end
                    if (phase == 3) begin alu = 3'd1; awe = 1'b1; am = 2'd1; end
                end
                3'd2: begin
                    if (INDEX_EN && phase == 0) ma = 2'd1;
                end
                3'd3: begin
                    if (phase == 0) ma = 2'd1;
                    if (phase == 1) begin ma = 2'd1; gwe = 1'b1; mwe = 1'b1; end
                    if (phase == 2) begin awe = 1'b1; am = 2'd3; end
                end
                3'd4: begin
                    if (phase == 0) ma = 2'd1;
                    if (phase == 1) begin awe = 1'b1; am = 2'd0; end
                    if (phase == 2) begin awe = 1'b1; am = 2'd2; end
                end
                3'd5: begin
                    ma = 2'd1; mwe = 1'b1;
                end
                3'd6, 3'd7: begin
                    if (phase == 0) ma = 2'd1;
                    if (phase == 1) begin ywe = 1'b1; ym = 2'd0; xwe = 1'b1; xm = 2'd3; end
                    if (phase == 2) begin alu = (op == 3'd7) ? 3'd4 : 3'd0; awe = 1'b1; am = 2'd1; end
                end
                default: ;
            endcase
        end
        return {alu, ma, 2'b00, am, xm, 2'b00, ym, 1'b0, 1'b0,
                1'b0, gwe, 1'b0, bwe, awe, ywe, xwe, 1'b0, mwe, dn};
    endfunction

    // synchronous-read memory; operand address is the current instruction's k
    always @(posedge clk) begin
        mem_data <= mem[(MAddr_MUX == 2'd0) ? pc_addr : m_k];
    end

    // instruction-level model of the sequencer
    always @(posedge clk) begin
        if (reset) begin
            m_phase <= PH_F0;
            m_pc    <= 12'h000;
            m_op    <= 3'd0;
            m_k     <= 12'h000;
            m_idx   <= 12'h000;
        end else if (m_phase == PH_F0) begin
            if (!halt) m_phase <= PH_F1;
        end else if (m_phase == PH_F1) begin
            m_op    <= mem_data[14:12];
            m_k     <= mem_data[11:0] + (INDEX_EN ? m_idx : 12'h000);
            m_idx   <= 12'h000;
            m_pc    <= m_pc + 12'd1;
            m_phase <= 0;
        end else begin
            if (m_op == 3'd0 && m_phase == 0) m_pc <= m_k;
            if (m_op == 3'd1 && m_phase == 2) m_pc <= m_pc + {10'd0, acc_sign, acc_zero};
            if (INDEX_EN && m_op == 3'd2 && m_phase == 1) m_idx <= mem_data[11:0];
            m_phase <= (m_phase == steps(m_op) - 1) ? PH_F0 : m_phase + 1;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("ctl_word", {5'd0, act}, {5'd0, exp_ctl(m_phase, m_op)});
            check("pc_addr", {20'd0, pc_addr}, {20'd0, m_pc});
            if (instr_done === 1'b1) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_pc(input logic [11:0] target, input int budget);
        int n;
        n = 0;
        while (pc_addr !== target && n < budget) begin
            step();
            n++;
        end
        check("wait_pc", {20'd0, pc_addr}, {20'd0, target});
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h000] = 16'h0040;  // TC 0o100
        mem[12'h040] = 16'h0004;  // TC 4
        mem[12'h004] = 16'h1200;  // CCS 0x200
        mem[12'h005] = 16'h0100;  // TC 0x100
        mem[12'h006] = 16'h0100;
        mem[12'h007] = 16'h0100;
        mem[12'h008] = 16'h3201;  // XCH
        mem[12'h009] = 16'h4202;  // CS
        mem[12'h00A] = 16'hD203;  // TS, bit 15 set
        mem[12'h00B] = 16'h7204;  // MASK
        mem[12'h00C] = 16'h2205;  // INDEX / NOOP
        mem[12'h00D] = 16'h0FFC;  // TC 0xFFC (+3 when indexed)
        mem[12'h100] = 16'h3210;  // XCH
        mem[12'h101] = 16'h6211;  // AD
        mem[12'h102] = 16'h0000;  // TC 0
        mem[12'h205] = 16'h0003;  // index value
        mem[12'hFFC] = 16'h0FFF;  // TC 0xFFF
        mem[12'hFFF] = 16'h6206;  // AD
        mem_data = 16'h0000;
        reset = 1'b1; halt = 1'b0; acc_sign = 1'b1; acc_zero = 1'b1;

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_pc", {20'd0, pc_addr}, 32'h000);
        check("reset_ctl", {5'd0, act}, 32'd0);
        done_cnt = 0;
        reset = 1'b0;

        // TC 0o100
        step();
        check("tc_f1_bwe", 32'(B_WE), 32'd1);
        step();
        check("tc_e0_pc", {20'd0, pc_addr}, 32'h001);
        check("tc_e0_done", 32'(instr_done), 32'd1);
        step();
        check("tc_target", {20'd0, pc_addr}, 32'h040);
        check("tc_done_cnt", done_cnt, 32'd1);

        // CCS with -0
        wait_pc(12'h004, 40);
        step();
        step();
        check("ccs_e0_pc", {20'd0, pc_addr}, 32'h005);
        step();
        step();
        step();
        check("ccs_skip_pc", {20'd0, pc_addr}, 32'h008);
        check("ccs_alu", 32'(alu_op), 32'd1);
        check("ccs_awe", 32'(A_WE), 32'd1);
        check("ccs_amux", 32'(A_MUX), 32'd1);

        // opcode 2
        wait_pc(12'h00D, 100);
`ifdef AGC_INDEX_EN
        check("index_e0", {5'd0, act}, 32'h0400000);
        step();
        check("index_e1", {5'd0, act}, 32'd1);
`else
        check("noop_e0", {5'd0, act}, 32'd1);
`endif

        // AD at 0xFFF wraps pc
        wait_pc(12'hFFF, 100);
        step();
        step();
        check("ad_wrap_pc", {20'd0, pc_addr}, 32'h000);
        step();
        step();
        check("ad_alu", 32'(alu_op), 32'd0);
        check("ad_awe", 32'(A_WE), 32'd1);
        check("ad_amux", 32'(A_MUX), 32'd1);

        // +0 takes the second skip slot
        acc_sign = 1'b0; acc_zero = 1'b1;
        wait_pc(12'h100, 100);

        // halt in F0
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("halt_f0_pc", {20'd0, pc_addr}, 32'h100);
            check("halt_f0_ctl", {5'd0, act}, 32'd0);
        end
        halt = 1'b0;
        step();
        step();
        step();
        halt = 1'b1;  // raised during XCH E1
        step();
        check("xch_e2_awe", 32'(A_WE), 32'd1);
        check("xch_e2_amux", 32'(A_MUX), 32'd3);
        check("xch_e2_done", 32'(instr_done), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_stall_pc", {20'd0, pc_addr}, 32'h101);
            check("halt_stall_ctl", {5'd0, act}, 32'd0);
        end
        halt = 1'b0;

        // reset during AD E1
        step();
        step();
        step();
        check("ad_e1_ywe", 32'(Y_WE), 32'd1);
        check("ad_e1_xwe", 32'(X_WE), 32'd1);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_ad_ctl", {5'd0, act}, 32'd0);
            check("reset_ad_pc", {20'd0, pc_addr}, 32'h000);
        end
        reset = 1'b0;

        // <-0 takes the third skip slot; free run under the model
        acc_sign = 1'b1; acc_zero = 1'b0;
        for (int i = 0; i < 120; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
